bw_r_rf_dwl_param: RTL
======================

// Module: bw_r_rf_dwl_param
// PURPOSE
//  Parametrised DEPTH x WIDTH register file, 1 read + 1 write port, decoded (one-hot) wordlines.
//  Next-generation L2 tag/queue storage macro for sctag queues.
//  Adds over the fixed 16x128 macro:
//   - per-byte write enables
//   - a registered (deterministic) read port
//   - configurable read/write-collision bypass
//   - sticky wordline error flags in place of X propagation.
// PARAMETERS
//  WIDTH   128  data width in bits; must be a multiple of 8
//  DEPTH   16   number of entries = wordline width; must be >= 2
//  BYPASS  1    1: same-entry read+write returns new (merged) data; 0: returns old data
//  Derived: NBYTE = WIDTH/8, AW = $clog2(DEPTH)
// PORTS
//  rclk        in   1      clock; all state updates on posedge
//  reset_l     in   1      synchronous reset, active low
//  din         in   WIDTH  write data
//  wr_wl       in   DEPTH  write wordlines, one-hot or zero
//  wr_en       in   1      write enable
//  byte_wen    in   NBYTE  per-byte write enable; bit i covers din[8i+7:8i]
//  rd_wl       in   DEPTH  read wordlines, one-hot or zero
//  read_en     in   1      read enable
//  rst_tri_en  in   1      scan/test gating: suppresses writes, forces dout to all ones
//  sehold      in   1      holds the input-stage registers (scan hold)
//  err_clr     in   1      clears rd_err / wr_err
//  dout        out  WIDTH  registered read data
//  rd_err      out  1      sticky: read attempted with a non-one-hot rd_wl
//  wr_err      out  1      sticky: write attempted with a non-one-hot wr_wl
// BEHAVIOUR
//  Stage 1 (edge N)
//   - Registers din, wr_wl, wr_en, byte_wen, rd_wl, read_en -> *_d1.
//   - If sehold=1, every *_d1 keeps its value.
//   - rst_tri_en_d1 always samples rst_tri_en; sehold does not affect it.
//  Stage 2 (edge N+1), all actions on the same edge
//   - Write commit: if wr_en_d1 & ~rst_tri_en_d1 & wr_wl_d1 is one-hot, then
//     ary[enc(wr_wl_d1)] byte i <= din_d1 byte i for each byte_wen_d1[i]=1.
//   - Read: if read_en_d1=1:
//     - rst_tri_en_d1=1                 -> dout <= all ones
//     - else rd_wl_d1 zero              -> dout holds
//     - else rd_wl_d1 not one-hot       -> dout holds, rd_err <= 1
//     - else rd_wl_d1 == valid wr_wl_d1 -> BYPASS=1: bytes with byte_wen_d1=1 from din_d1,
//                                          remaining bytes from the array;
//                                          BYPASS=0: old array word
//     - else                            -> dout <= ary[enc(rd_wl_d1)]
//   - read_en_d1=0: dout holds.
//   - Write with wr_en_d1=1, ~rst_tri_en_d1, wr_wl_d1 not one-hot and nonzero:
//     no array update, wr_err <= 1.
//   - Write with wr_wl_d1 zero: no-op, no error.
//  Latency and ordering
//   - Read latency: 2 edges (inputs at N, dout valid after N+1).
//   - A write issued at edge N is visible to a read issued at edge N+1 or later.
//  Error flags
//   - err_clr=1 clears both flags.
//   - If set and clear happen on the same edge, set wins.
//  Reset (reset_l=0 at a posedge)
//   - Cleared to 0: dout, rd_err, wr_err, and all *_d1 registers (including rst_tri_en_d1).
//   - Array contents are not cleared; array writes are blocked during reset.
//   - Reset overrides sehold.
//   - Operations already in stage 1 are discarded.
//  No X is ever driven on dout or the flags after the first reset.
// STRUCTURE
//  Shared package bw_rf_pkg: one-hot check function, AW/NBYTE derivation, all-ones constant.
//  Sub-module bw_r_rf_ohenc (DEPTH -> AW one-hot encoder):
//   - outputs: zero, onehot, idx
//   - one instance each for the read and write wordlines.
//  Array: reg [WIDTH-1:0] ary[DEPTH]; byte-merge logic is shared by the write path and the bypass path.
// TESTING
//  1 Reset; write 0xA5.. to wl=0x0004 with all byte_wen; read wl=0x0004 two cycles later
//    -> dout=0xA5.. 2 edges after read issue.
//  2 Byte merge: entry 3 = all 0x11; write 0xFF.. with byte_wen=0x0001
//    -> read gives 0x1111..11FF.
//  3 Collision: same edge rd_wl=wr_wl=0x0100, entry=0x0, din=0x5A.., byte_wen all
//    -> dout=0x5A.. (BYPASS=1), 0x0 (BYPASS=0).
//  4 rd_wl=0x0003 with read_en -> dout unchanged, rd_err=1; err_clr pulse -> rd_err=0.
//    wr_wl=0x8001 -> no write, wr_err=1.
//  5 rst_tri_en=1 with read and write to entry 5 -> dout=all ones, entry 5 unchanged on later read.
//  6 sehold=1 while inputs toggle -> array and dout follow the held stage-1 values.
//    Then reset_l=0 mid-write -> dout=0, held write not committed.
//  Run DEPTH=16/WIDTH=128 and DEPTH=32/WIDTH=64 in both BYPASS modes; scoreboard checks every read.

Source files
------------

// File: rtl/bw_rf_pkg.sv
// Shared helpers for the parametrised register-file macros: size derivation,
// wordline one-hot test and the all-ones read pattern.
package bw_rf_pkg;

  localparam int MAX_DEPTH = 1024;
  localparam int MAX_WIDTH = 1024;
  localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

  function automatic int nbyte_f(input int width);
    return width / 8;
  endfunction

  function automatic int aw_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Callers zero-extend narrower wordlines into the MAX_DEPTH vector.
  function automatic logic is_onehot(input logic [MAX_DEPTH-1:0] v);
    return (v != '0) && ((v & (v - MAX_DEPTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/bw_r_rf_ohenc.sv
// Wordline classifier/encoder: flags zero and one-hot, and encodes the set bit.
module bw_r_rf_ohenc
  import bw_rf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = aw_f(DEPTH)
)(
  input  logic [DEPTH-1:0] wl,
  output logic             zero,
  output logic             onehot,
  output logic [AW-1:0]    idx
);

  logic [MAX_DEPTH-1:0] wl_ext_s;

  // Classify the wordline and OR-encode its set bit position.
  always_comb begin
    wl_ext_s            = '0;
    wl_ext_s[DEPTH-1:0] = wl;
    zero                = (wl == '0);
    onehot              = is_onehot(wl_ext_s);
    idx                 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wl[i]) begin
        idx = idx | AW'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/bw_r_rf_dwl_param.sv
// DEPTH x WIDTH register file, one read and one write port on decoded wordlines,
// byte write enables, registered read data and sticky wordline error flags.
module bw_r_rf_dwl_param
  import bw_rf_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 16,
  parameter int BYPASS = 1,
  localparam int NBYTE = nbyte_f(WIDTH),
  localparam int AW    = aw_f(DEPTH)
)(
  input  logic             rclk,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] din,
  input  logic [DEPTH-1:0] wr_wl,
  input  logic             wr_en,
  input  logic [NBYTE-1:0] byte_wen,
  input  logic [DEPTH-1:0] rd_wl,
  input  logic             read_en,
  input  logic             rst_tri_en,
  input  logic             sehold,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             rd_err,
  output logic             wr_err
);

  logic [WIDTH-1:0] din_d1_r;
  logic [DEPTH-1:0] wr_wl_d1_r;
  logic             wr_en_d1_r;
  logic [NBYTE-1:0] byte_wen_d1_r;
  logic [DEPTH-1:0] rd_wl_d1_r;
  logic             read_en_d1_r;
  logic             rst_tri_en_d1_r;

  logic [WIDTH-1:0] ary_r [DEPTH];
  logic [WIDTH-1:0] dout_r;
  logic             rd_err_r;
  logic             wr_err_r;

  logic             rd_zero_s, rd_onehot_s, wr_zero_s, wr_onehot_s;
  logic [AW-1:0]    rd_idx_s, wr_idx_s;
  logic [WIDTH-1:0] wr_word_s, rd_word_s, merged_s, dout_next_s;
  logic             wr_act_s, wr_valid_s, wr_commit_s, collide_s;
  logic             rd_err_set_s, wr_err_set_s;

  bw_r_rf_ohenc #(.DEPTH(DEPTH), .AW(AW)) u_rd_enc (
    .wl     (rd_wl_d1_r),
    .zero   (rd_zero_s),
    .onehot (rd_onehot_s),
    .idx    (rd_idx_s)
  );

  bw_r_rf_ohenc #(.DEPTH(DEPTH), .AW(AW)) u_wr_enc (
    .wl     (wr_wl_d1_r),
    .zero   (wr_zero_s),
    .onehot (wr_onehot_s),
    .idx    (wr_idx_s)
  );

  // One merge feeds both the array write and the collision bypass, since a
  // colliding read addresses the same entry as the write.
  for (genvar b = 0; b < NBYTE; b++) begin : g_merge
    assign merged_s[8*b +: 8] = byte_wen_d1_r[b] ? din_d1_r[8*b +: 8] : wr_word_s[8*b +: 8];
  end

  // Stage-2 decode of the captured operation.
  always_comb begin
    wr_word_s    = ary_r[wr_idx_s];
    rd_word_s    = ary_r[rd_idx_s];
    wr_act_s     = wr_en_d1_r & ~rst_tri_en_d1_r;
    wr_valid_s   = wr_act_s & wr_onehot_s;
    wr_commit_s  = wr_valid_s & reset_l;
    wr_err_set_s = wr_act_s & ~wr_zero_s & ~wr_onehot_s;
    rd_err_set_s = read_en_d1_r & ~rst_tri_en_d1_r & ~rd_zero_s & ~rd_onehot_s;
    collide_s    = wr_valid_s & rd_onehot_s & (rd_wl_d1_r == wr_wl_d1_r);
  end

  // Next read data; a bad or empty wordline leaves dout untouched.
  always_comb begin
    dout_next_s = dout_r;
    if (read_en_d1_r) begin
      if (rst_tri_en_d1_r) begin
        dout_next_s = ALL_ONES[WIDTH-1:0];
      end else if (rd_zero_s || !rd_onehot_s) begin
        dout_next_s = dout_r;
      end else if (collide_s && (BYPASS != 0)) begin
        dout_next_s = merged_s;
      end else begin
        dout_next_s = rd_word_s;
      end
    end else begin
      dout_next_s = dout_r;
    end
  end

  // Stage-1 capture; sehold freezes it except for the test-gating bit.
  always_ff @(posedge rclk) begin
    if (!reset_l) begin
      din_d1_r        <= '0;
      wr_wl_d1_r      <= '0;
      wr_en_d1_r      <= 1'b0;
      byte_wen_d1_r   <= '0;
      rd_wl_d1_r      <= '0;
      read_en_d1_r    <= 1'b0;
      rst_tri_en_d1_r <= 1'b0;
    end else begin
      rst_tri_en_d1_r <= rst_tri_en;
      if (!sehold) begin
        din_d1_r      <= din;
        wr_wl_d1_r    <= wr_wl;
        wr_en_d1_r    <= wr_en;
        byte_wen_d1_r <= byte_wen;
        rd_wl_d1_r    <= rd_wl;
        read_en_d1_r  <= read_en;
      end
    end
  end

  // Read data and sticky flags; a new error beats a same-edge clear.
  always_ff @(posedge rclk) begin
    if (!reset_l) begin
      dout_r   <= '0;
      rd_err_r <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      dout_r   <= dout_next_s;
      rd_err_r <= rd_err_set_s ? 1'b1 : (err_clr ? 1'b0 : rd_err_r);
      wr_err_r <= wr_err_set_s ? 1'b1 : (err_clr ? 1'b0 : wr_err_r);
    end
  end

  // Storage is never reset, so contents survive reset; the commit is blocked instead.
  always_ff @(posedge rclk) begin
    if (wr_commit_s) begin
      ary_r[wr_idx_s] <= merged_s;
    end
  end

  assign dout   = dout_r;
  assign rd_err = rd_err_r;
  assign wr_err = wr_err_r;

endmodule
